// File: rtl/proc_control_pkg.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_pkg
// Description : Shared opcode constants, step encoding and default data width
//               for the proc_control datapath controller.
// Revision    : 1.0 - initial release
// ============================================================================
package proc_control_pkg;

  localparam int DW_DEFAULT = 16;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage
`default_nettype wire

// File: rtl/proc_control_if.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_if
// Description : Bus bundle between proc_control and the reg16 register file:
//               start request, external data, flattened register outputs,
//               shared bus, one-hot load enables and done flag.
// Revision    : 1.0 - initial release
// ============================================================================
interface proc_control_if
  import proc_control_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = 8
);

  logic               run;
  logic [DW-1:0]      din;
  logic [NREG*DW-1:0] r_all;
  logic [DW-1:0]      buswires;
  logic [NREG-1:0]    rin;
  logic               done;

  // Environment side: issues instructions and presents register contents.
  modport master (
    output run, din, r_all,
    input  buswires, rin, done
  );

  // Controller side.
  modport slave (
    input  run, din, r_all,
    output buswires, rin, done
  );

endinterface
`default_nettype wire

// File: rtl/proc_control_addsub.sv
`default_nettype none
// ============================================================================
// Module      : proc_control_addsub
// Description : Combinational modulo-2^DW adder/subtractor; carry and borrow
//               are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_control_addsub
  import proc_control_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic [DW-1:0] a,
  input  wire logic [DW-1:0] b,
  input  wire logic          sub,
  output logic      [DW-1:0] sum
);

  // Sub selects a - b, otherwise a + b; result truncated to DW bits.
  always_comb begin
    sum = sub ? (a - b) : (a + b);
  end

endmodule
`default_nettype wire

// File: rtl/reg16.sv
`default_nettype none
// ============================================================================
// Module      : reg16
// Description : General-purpose register; captures buswires on the rising
//               edge when rin is high.
// Revision    : 1.0 - initial release
// ============================================================================
module reg16
  import proc_control_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  wire logic          clock,
  input  wire logic          rin,
  input  wire logic [DW-1:0] buswires,
  output logic      [DW-1:0] q
);

  logic [DW-1:0] data_d;
  logic [DW-1:0] data_q;

  // Load the bus when enabled, otherwise hold.
  always_comb begin
    data_d = rin ? buswires : data_q;
  end

  // Storage register.
  always_ff @(posedge clock) begin
    data_q <= data_d;
  end

  assign q = data_q;

endmodule
`default_nettype wire

// File: rtl/proc_control.sv
`default_nettype none
// ============================================================================
// Module      : proc_control
// Description : Instruction fetch, T0..T3 step sequencer, accumulator A,
//               result register G and bus multiplexer driving the reg16 file.
// Revision    : 1.0 - initial release
// ============================================================================
module proc_control
  import proc_control_pkg::*;
#(
  parameter int DW   = DW_DEFAULT,
  parameter int NREG = 8
) (
  input  wire logic   clock,
  input  wire logic   reset,
  proc_control_if.slave bus
);

  step_t         step_d, step_q;
  logic [8:0]    ir_d,   ir_q;
  logic [DW-1:0] a_d,    a_q;
  logic [DW-1:0] g_d,    g_q;

  logic [DW-1:0]   bus_w;
  logic [NREG-1:0] rin_w;
  logic            done_w;

  logic [2:0]      op_w, x_w, y_w;
  logic [DW-1:0]   rx_w, ry_w, sum_w;
  logic [NREG-1:0] rin_x_w;

  // Decode instruction fields and select the two operand registers.
  always_comb begin
    op_w    = ir_q[8:6];
    x_w     = ir_q[5:3];
    y_w     = ir_q[2:0];
    rx_w    = bus.r_all[x_w*DW +: DW];
    ry_w    = bus.r_all[y_w*DW +: DW];
    rin_x_w = NREG'(1) << x_w;
  end

  // G is only loaded in T2, where the bus carries Ry, so Ry feeds the adder
  // directly and keeps the bus mux out of the arithmetic path.
  proc_control_addsub #(.DW(DW)) u_addsub (
    .a   (a_q),
    .b   (ry_w),
    .sub (op_w == OP_SUB),
    .sum (sum_w)
  );

  // Step sequencing, register next-state and bus/enable outputs.
  always_comb begin
    step_d = step_q;
    ir_d   = ir_q;
    a_d    = a_q;
    g_d    = g_q;
    bus_w  = '0;
    rin_w  = '0;
    done_w = 1'b0;
    case (step_q)
      T0: begin
        if (bus.run) begin
          ir_d   = bus.din[8:0];
          step_d = T1;
        end
      end
      T1: begin
        step_d = T0;
        case (op_w)
          OP_MV: begin
            bus_w  = ry_w;
            rin_w  = rin_x_w;
            done_w = 1'b1;
          end
          OP_MVI: begin
            bus_w  = bus.din;
            rin_w  = rin_x_w;
            done_w = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            bus_w  = rx_w;
            a_d    = rx_w;
            step_d = T2;
          end
          default: begin
            done_w = 1'b1;
          end
        endcase
      end
      T2: begin
        bus_w  = ry_w;
        g_d    = sum_w;
        step_d = T3;
      end
      T3: begin
        bus_w  = g_q;
        rin_w  = rin_x_w;
        done_w = 1'b1;
        step_d = T0;
      end
      default: step_d = T0;
    endcase
    // Reset suppresses every write so an aborted instruction leaves no trace.
    if (reset) begin
      bus_w  = '0;
      rin_w  = '0;
      done_w = 1'b0;
    end
  end

  // State, instruction, accumulator and result registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      step_q <= T0;
      ir_q   <= '0;
      a_q    <= '0;
      g_q    <= '0;
    end else begin
      step_q <= step_d;
      ir_q   <= ir_d;
      a_q    <= a_d;
      g_q    <= g_d;
    end
  end

  assign bus.buswires = bus_w;
  assign bus.rin      = rin_w;
  assign bus.done     = done_w;

endmodule
`default_nettype wire

// File: tb/tb_proc_control.sv
`default_nettype none
// ============================================================================
// Module      : tb_proc_control
// Description : Self-checking bench for proc_control driving eight reg16
//               registers; expected per-cycle outputs go through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_proc_control;
  import proc_control_pkg::*;

  localparam int DW   = 16;
  localparam int NREG = 8;

  typedef struct {
    string        tag;
    logic [15:0]  bus;
    logic [7:0]   rin;
    logic         done;
  } exp_t;

  logic clk;
  logic reset;
  logic [15:0] rq [NREG];
  logic [15:0] model [NREG];
  exp_t sb [$];
  int n_checks;
  int n_errors;

  proc_control_if #(.DW(DW), .NREG(NREG)) bus_if ();

  proc_control #(.DW(DW), .NREG(NREG)) dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  for (genvar gi = 0; gi < NREG; gi++) begin : g_regs
    reg16 #(.DW(DW)) u_reg (
      .clock    (clk),
      .rin      (bus_if.rin[gi]),
      .buswires (bus_if.buswires),
      .q        (rq[gi])
    );
  end

  always_comb begin
    for (int i = 0; i < NREG; i++) bus_if.r_all[i*DW +: DW] = rq[i];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one cycle at a negedge, push its expectation, sample and compare.
  task automatic step(input logic r, input logic [15:0] d, input logic rst_v,
                      input logic [15:0] eb, input logic [7:0] er, input logic ed,
                      input string tag);
    exp_t e;
    reset      = rst_v;
    bus_if.run = r;
    bus_if.din = d;
    sb.push_back('{tag, eb, er, ed});
    #2;
    e = sb.pop_front();
    check_val({e.tag, ".bus"},  32'(bus_if.buswires), 32'(e.bus));
    check_val({e.tag, ".rin"},  32'(bus_if.rin),      32'(e.rin));
    check_val({e.tag, ".done"}, 32'(bus_if.done),     32'(e.done));
    @(negedge clk);
  endtask

  // Issue one instruction and check every step plus the destination register.
  task automatic exec(input logic [2:0] op, input logic [2:0] x, input logic [2:0] y,
                      input logic [15:0] imm, input logic hold_run, input string tag);
    logic [15:0] res;
    logic [7:0]  oh;
    oh = 8'd1 << x;
    step(1'b1, {7'd0, op, x, y}, 1'b0, 16'h0, 8'h0, 1'b0, {tag, ".t0"});
    case (op)
      OP_MV: begin
        step(hold_run, 16'h0, 1'b0, model[y], oh, 1'b1, {tag, ".t1"});
        model[x] = model[y];
      end
      OP_MVI: begin
        step(1'b0, imm, 1'b0, imm, oh, 1'b1, {tag, ".t1"});
        model[x] = imm;
      end
      OP_ADD, OP_SUB: begin
        res = (op == OP_ADD) ? model[x] + model[y] : model[x] - model[y];
        step(1'b0, 16'h0, 1'b0, model[x], 8'h0, 1'b0, {tag, ".t1"});
        step(1'b0, 16'h0, 1'b0, model[y], 8'h0, 1'b0, {tag, ".t2"});
        step(1'b0, 16'h0, 1'b0, res, oh, 1'b1, {tag, ".t3"});
        model[x] = res;
      end
      default: begin
        step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b1, {tag, ".t1"});
      end
    endcase
    if (op[2] == 1'b0) check_val({tag, ".reg"}, 32'(rq[x]), 32'(model[x]));
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b1;
    bus_if.run = 1'b0;
    bus_if.din = '0;
    for (int i = 0; i < NREG; i++) model[i] = 16'h0;
    @(negedge clk);

    step(1'b0, 16'h0, 1'b1, 16'h0, 8'h0, 1'b0, "rst0");
    step(1'b0, 16'h0, 1'b1, 16'h0, 8'h0, 1'b0, "rst1");
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0, "idle");

    exec(OP_MVI, 3'd1, 3'd0, 16'h1234, 1'b0, "mvi_r1");
    exec(OP_MV,  3'd3, 3'd1, 16'h0,    1'b0, "mv_r3_r1");
    exec(OP_ADD, 3'd1, 3'd3, 16'h0,    1'b0, "add_r1_r3");
    check_val("add_val", 32'(rq[1]), 32'h2468);

    exec(OP_MVI, 3'd0, 3'd0, 16'h0000, 1'b0, "mvi_r0");
    exec(OP_MVI, 3'd5, 3'd0, 16'h0001, 1'b0, "mvi_r5");
    exec(OP_SUB, 3'd0, 3'd5, 16'h0,    1'b0, "sub_wrap");
    check_val("sub_val", 32'(rq[0]), 32'hFFFF);
    exec(OP_ADD, 3'd0, 3'd5, 16'h0,    1'b0, "add_wrap");
    check_val("addw_val", 32'(rq[0]), 32'h0000);

    exec(OP_MVI, 3'd2, 3'd0, 16'h0101, 1'b0, "mvi_r2");
    exec(OP_ADD, 3'd2, 3'd2, 16'h0,    1'b0, "add_r2_r2");
    check_val("dbl_val", 32'(rq[2]), 32'h0202);

    exec(3'b100, 3'd6, 3'd7, 16'h0, 1'b0, "nop");

    // run held high through T1 of an mv must not start a new instruction.
    exec(OP_MVI, 3'd0, 3'd0, 16'hA5C3, 1'b0, "mvi_r0b");
    exec(OP_MV,  3'd4, 3'd0, 16'h0,    1'b1, "mv_hold");
    step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0, "hold_idle");

    // Reset during T2 of an add aborts it without writing R1.
    step(1'b1, {7'd0, OP_ADD, 3'd1, 3'd3}, 1'b0, 16'h0, 8'h0, 1'b0, "abort.t0");
    step(1'b0, 16'h0, 1'b0, model[1], 8'h0, 1'b0, "abort.t1");
    step(1'b0, 16'h0, 1'b1, 16'h0, 8'h0, 1'b0, "abort.rst");
    step(1'b0, 16'h0, 1'b0, 16'h0, 8'h0, 1'b0, "abort.idle");
    check_val("abort.reg", 32'(rq[1]), 32'h2468);

    exec(OP_ADD, 3'd1, 3'd3, 16'h0, 1'b0, "add_after");
    check_val("after_val", 32'(rq[1]), 32'h369C);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
